xdma_axis_unpack: RTL
=====================

Name: xdma_axis_unpack

Overview:
Downstream consumer of the difftest XDMA AXI-Stream. Takes beats from the batch-packet sender and rebuilds each difftest packet: a DATA_WIDTH payload plus an 8-bit group sequence byte. Packets are presented on a valid/ready port, and stream framing and sequence integrity are checked. Used on the receive side of the FPGA-sim loopback, and as the reference decoder in the difftest FPGA testbench.

Parameters:
- DATA_WIDTH, 16000, difftest payload bits per packet.
- AXIS_DATA_WIDTH, 512, AXI-Stream beat width.
- PKTS_PER_GROUP, 8, packets per tlast-delimited group.
- SEND_LEN, derived (not overridable), beats per packet = (DATA_WIDTH+8+AXIS_DATA_WIDTH-1)/AXIS_DATA_WIDTH.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- s_axis_tdata  in  AXIS_DATA_WIDTH  stream beat.
- s_axis_tkeep  in  AXIS_DATA_WIDTH/8  ignored; producer drives all ones.
- s_axis_tlast  in  1  last beat of group.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  beat accept.
- out_valid  out  1  reassembled packet valid.
- out_ready  in  1  consumer accept.
- out_data  out  DATA_WIDTH  payload.
- out_seq  out  8  group sequence byte; valid when out_first=1, else 0.
- out_first  out  1  first packet of group.
- out_last  out  1  last packet of group.
- seq_err  out  1  sticky sequence/padding error.
- tlast_err  out  1  sticky framing error.
- err_clear  in  1  clears both sticky errors, one cycle.
- group_cnt  out  32  groups completed without framing error; wraps.

Behaviour:
- Reset, async: s_axis_tready=0 while reset asserted, then per rule below. All outputs 0, beat_cnt=0, pkt_cnt=0, expected_seq=0, state=RECV.
- Wire format: beats are LSB-first. Beat k of a packet lands at asm[k*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH].
- Packet decode: asm[7:0]=sequence byte, asm[8 +: DATA_WIDTH]=payload. Bits above DATA_WIDTH+8 are don't-care.
- Beat accepted on tvalid&tready. beat_cnt counts 0..SEND_LEN-1; pkt_cnt counts 0..PKTS_PER_GROUP-1.
- tready (RECV) = !(beat_cnt==SEND_LEN-1 && out_valid && !out_ready). Collection continues while the output is held; only the completing beat stalls. tready must not depend on tvalid.
- Output register, single entry:
  - Loaded on the cycle after the completing beat is accepted (latency 1).
  - Loaded with out_first=(pkt_cnt==0), out_last=(pkt_cnt==PKTS_PER_GROUP-1), out_seq=asm[7:0] if first else 0.
  - Held stable while out_valid&!out_ready.
  - Simultaneous pop and load is allowed: 1 packet/SEND_LEN cycles at full rate.
- Sequence check, on the completing beat:
  - First packet: asm[7:0]!=expected_seq sets seq_err. expected_seq <= asm[7:0]+1 (mod 256), resyncing.
  - Non-first packet: nonzero asm[7:0] sets seq_err.
  - The packet is still delivered.
- FSM states: RECV, DROP.
  - RECV, tlast on non-final beat of group (early): set tlast_err, discard partial packet, beat_cnt=pkt_cnt=0, stay RECV. Packets already delivered stand.
  - RECV, final beat of group without tlast: set tlast_err, deliver that packet, go DROP, no group_cnt increment.
  - RECV, final beat with tlast: group_cnt+1, counters to 0.
  - DROP: tready=1, beats discarded. Accepted beat with tlast -> RECV, counters 0.
- Sticky errors: err_clear has priority over a new error set in the same cycle.
- Reset mid-packet: partial assembly and any held output are discarded.

Decomposition:
- Shared package xdma_pkg: SEND_LEN computation function, SEQ_W=8, default PKTS_PER_GROUP=8. The sender side uses the same package so both ends agree on framing.
- One natural sub-module: xdma_pkt_outreg, the single-entry valid/ready output register with simultaneous load/pop. The rest stays flat.

Test Plan:
- Config DATA_WIDTH=1000, AXIS_DATA_WIDTH=512 (SEND_LEN=2). One clean group, seq byte 0x00, payload i in packet i, tlast on beat 15, out_ready=1 -> 8 outputs, payloads 0..7. First output out_first=1, out_seq=0x00; last output out_last=1. group_cnt=1, no errors.
- Two back-to-back groups with seq 0x00 and 0x01, tvalid continuous -> 16 packets, tready never drops, group_cnt=2. Then a group with seq 0x05 -> seq_err=1, packets delivered; a following group with 0x06 gives no new error.
- Backpressure: out_ready=0 for 10 cycles mid-group -> tready low only on completing beats, out_data stable. Release delivers all 8 packets in order, none lost or duplicated.
- tlast on beat 5 -> tlast_err=1, partial packet 2 dropped, 2 packets delivered. Next clean group decodes correctly, group_cnt increments.
- Missing tlast on beat 15 -> 8th packet delivered, tlast_err=1, extra 3 beats discarded up to tlast. Next group clean, group_cnt unchanged for the bad group.
- Async reset asserted mid-packet with out_valid=1 -> out_valid=0 immediately. After release, a group with seq 0x00 gives no seq_err; err_clear pulse clears the sticky flags.

Source files
------------

// File: rtl/xdma_pkg.sv
// Framing definitions shared by the XDMA AXI-Stream difftest sender and unpacker.
// Both ends import this package, so they always agree on the packet and group layout.
package xdma_pkg;

  localparam int SEQ_W                  = 8;
  localparam int DEFAULT_PKTS_PER_GROUP = 8;

  typedef enum logic {
    ST_RECV = 1'b0,
    ST_DROP = 1'b1
  } unpack_state_e;

  // Number of stream beats needed to carry one payload plus its sequence byte.
  function automatic int send_len(input int data_width, input int axis_width);
    return (data_width + SEQ_W + axis_width - 1) / axis_width;
  endfunction

endpackage

// File: rtl/xdma_pkt_outreg.sv
// Single-entry valid/ready holding register for reassembled packets.
// A load and a pop may happen in the same cycle, so a full-rate stream never bubbles.
module xdma_pkt_outreg
  import xdma_pkg::*;
#(
  parameter int DATA_WIDTH = 16000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [SEQ_W-1:0]      load_seq,
  input  logic                  load_first,
  input  logic                  load_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [SEQ_W-1:0]      out_seq,
  output logic                  out_first,
  output logic                  out_last
);

  // The producer never loads while the entry is held, so a load always wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_seq   <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_seq   <= load_seq;
      out_first <= load_first;
      out_last  <= load_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/xdma_axis_unpack.sv
// Rebuilds difftest packets from the XDMA AXI-Stream and checks group framing and sequence.
// state   | meaning
// RECV    | collecting beats into packets, checking tlast position and sequence bytes
// DROP    | final packet arrived without tlast; discarding beats until a tlast is seen
module xdma_axis_unpack
  import xdma_pkg::*;
#(
  parameter int DATA_WIDTH      = 16000,
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int PKTS_PER_GROUP  = DEFAULT_PKTS_PER_GROUP
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                         s_axis_tlast,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [SEQ_W-1:0]             out_seq,
  output logic                         out_first,
  output logic                         out_last,
  output logic                         seq_err,
  output logic                         tlast_err,
  input  logic                         err_clear,
  output logic [31:0]                  group_cnt
);

  localparam int SEND_LEN = send_len(DATA_WIDTH, AXIS_DATA_WIDTH);
  localparam int ASM_W    = SEND_LEN * AXIS_DATA_WIDTH;
  localparam int BEAT_W   = (SEND_LEN > 1) ? $clog2(SEND_LEN) : 1;
  localparam int PKT_W    = (PKTS_PER_GROUP > 1) ? $clog2(PKTS_PER_GROUP) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(SEND_LEN - 1);
  localparam logic [PKT_W-1:0]  LAST_PKT  = PKT_W'(PKTS_PER_GROUP - 1);

  unpack_state_e        state_q, state_d;
  logic [BEAT_W-1:0]    beat_cnt, beat_cnt_d;
  logic [PKT_W-1:0]     pkt_cnt, pkt_cnt_d;
  logic [SEQ_W-1:0]     expected_seq, expected_seq_d;
  logic [31:0]          group_cnt_d;
  logic                 tready_int, asm_we, load, seq_set, tlast_set;
  logic                 is_last_beat, is_final_beat;

  logic [AXIS_DATA_WIDTH-1:0] asm_q [SEND_LEN];
  logic [ASM_W-1:0]           asm_full;
  logic [SEQ_W-1:0]           seq_byte;
  logic                       unused_ok;

  // The completing beat is spliced in combinationally so it loads straight into the output.
  always_comb begin
    asm_full = '0;
    for (int k = 0; k < SEND_LEN; k++) begin
      asm_full[k*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] =
        (BEAT_W'(k) == beat_cnt) ? s_axis_tdata : asm_q[k];
    end
  end

  assign seq_byte      = asm_full[SEQ_W-1:0];
  assign is_last_beat  = (beat_cnt == LAST_BEAT);
  assign is_final_beat = is_last_beat && (pkt_cnt == LAST_PKT);
  assign unused_ok     = ^{s_axis_tkeep, asm_full};

  always_comb begin
    state_d        = state_q;
    beat_cnt_d     = beat_cnt;
    pkt_cnt_d      = pkt_cnt;
    expected_seq_d = expected_seq;
    group_cnt_d    = group_cnt;
    tready_int     = 1'b0;
    asm_we         = 1'b0;
    load           = 1'b0;
    seq_set        = 1'b0;
    tlast_set      = 1'b0;
    case (state_q)
      ST_RECV: begin
        tready_int = !(is_last_beat && out_valid && !out_ready);
        if (s_axis_tvalid && tready_int) begin
          if (s_axis_tlast && !is_final_beat) begin
            tlast_set  = 1'b1;
            beat_cnt_d = '0;
            pkt_cnt_d  = '0;
          end else if (is_last_beat) begin
            load       = 1'b1;
            beat_cnt_d = '0;
            if (pkt_cnt == '0) begin
              seq_set        = (seq_byte != expected_seq);
              expected_seq_d = seq_byte + 8'd1;
            end else begin
              seq_set = (seq_byte != '0);
            end
            if (pkt_cnt == LAST_PKT) begin
              pkt_cnt_d = '0;
              if (s_axis_tlast) begin
                group_cnt_d = group_cnt + 32'd1;
              end else begin
                tlast_set = 1'b1;
                state_d   = ST_DROP;
              end
            end else begin
              pkt_cnt_d = pkt_cnt + 1'b1;
            end
          end else begin
            asm_we     = 1'b1;
            beat_cnt_d = beat_cnt + 1'b1;
          end
        end
      end
      ST_DROP: begin
        tready_int = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          state_d    = ST_RECV;
          beat_cnt_d = '0;
          pkt_cnt_d  = '0;
        end
      end
      default: state_d = ST_RECV;
    endcase
  end

  assign s_axis_tready = tready_int && !reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RECV;
      beat_cnt     <= '0;
      pkt_cnt      <= '0;
      expected_seq <= '0;
      group_cnt    <= '0;
      seq_err      <= 1'b0;
      tlast_err    <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt     <= beat_cnt_d;
      pkt_cnt      <= pkt_cnt_d;
      expected_seq <= expected_seq_d;
      group_cnt    <= group_cnt_d;
      if (err_clear)    seq_err <= 1'b0;
      else if (seq_set) seq_err <= 1'b1;
      if (err_clear)      tlast_err <= 1'b0;
      else if (tlast_set) tlast_err <= 1'b1;
    end
  end

  // Partial packets are tracked by beat_cnt, so the beat store itself needs no reset.
  always_ff @(posedge clock) begin
    if (asm_we) asm_q[beat_cnt] <= s_axis_tdata;
  end

  xdma_pkt_outreg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_outreg (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_data  (asm_full[SEQ_W +: DATA_WIDTH]),
    .load_seq   ((pkt_cnt == '0) ? seq_byte : '0),
    .load_first (pkt_cnt == '0),
    .load_last  (pkt_cnt == LAST_PKT),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_seq    (out_seq),
    .out_first  (out_first),
    .out_last   (out_last)
  );

endmodule
